// File: rtl/mode_select_ctrl_if.sv
// Bundles the menu controls, pixel position, ROM handshakes and the
// game-core handoff of the MODE SELECT banner controller into one port.
// The slave modport is the controller's view; master is the video/game side.
interface mode_select_ctrl_if;
    logic        frame_tick;
    logic        btn_up;
    logic        btn_down;
    logic        btn_sel;
    logic        game_over;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        video_on;
    logic [7:0]  char_xy;
    logic [6:0]  char_code_in;
    logic [10:0] font_addr;
    logic [7:0]  font_row_in;
    logic        text_on;
    logic [3:0]  mode;
    logic        mode_valid;
    logic        start_game;

    modport slave (
        input  frame_tick, btn_up, btn_down, btn_sel, game_over,
        input  pix_x, pix_y, video_on, char_code_in, font_row_in,
        output char_xy, font_addr, text_on, mode, mode_valid, start_game
    );

    modport master (
        output frame_tick, btn_up, btn_down, btn_sel, game_over,
        output pix_x, pix_y, video_on, char_code_in, font_row_in,
        input  char_xy, font_addr, text_on, mode, mode_valid, start_game
    );
endinterface

// File: rtl/mode_select_ctrl.sv
// Mode-select menu controller for the Pong "MODE      SELECT" banner.
// Runs the MENU/CONFIRM/PLAY FSM, addresses the banner char ROM, swaps the
// mode digit into column 5 and produces a 3-clock pipelined text_on pixel.
// Optional macro MODE_SEL_BLINK_EN: when defined the column-5 digit blinks
// in MENU; when undefined the digit is always shown.
module mode_select_ctrl #(
    parameter int NUM_MODES      = 3,
    parameter int TEXT_X0        = 256,
    parameter int TEXT_Y0        = 112,
    parameter int CONFIRM_FRAMES = 30,
    parameter int BLINK_FRAMES   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    mode_select_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        MENU    = 2'd0,
        CONFIRM = 2'd1,
        PLAY    = 2'd2
    } state_t;

    localparam logic [3:0] L_MAX_MODE = 4'(NUM_MODES - 1);
    localparam int         L_CW       = $clog2(CONFIRM_FRAMES) + 1;
    localparam logic [L_CW-1:0] L_CONF_LAST = L_CW'(CONFIRM_FRAMES - 1);
    localparam logic [9:0] L_X0 = 10'(TEXT_X0);
    localparam logic [9:0] L_Y0 = 10'(TEXT_Y0);

    state_t          r_state;
    state_t          w_stateNext;
    logic [3:0]      r_mode;
    logic [3:0]      w_modeNext;
    logic            r_startGame;
    logic [L_CW-1:0] r_confCnt;
    logic            w_phase;

    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic        w_inBox;
    logic [3:0]  w_col;
    logic [6:0]  w_code;
    logic [10:0] r_fontAddr;
    logic        r_inBox1;
    logic [2:0]  r_bit1;
    logic        r_inBox2;
    logic [2:0]  r_bit2;
    logic [2:0]  w_bitSel;
    logic        r_textOn;

    // Next-state and next-mode decision; select beats a same-cycle up/down
    always_comb begin
        w_stateNext = r_state;
        w_modeNext  = r_mode;
        case (r_state)
            MENU: begin
                if (bus.btn_sel) begin
                    w_stateNext = CONFIRM;
                end else if (bus.btn_up && !bus.btn_down) begin
                    w_modeNext = (r_mode == L_MAX_MODE) ? 4'd0 : r_mode + 4'd1;
                end else if (bus.btn_down && !bus.btn_up) begin
                    w_modeNext = (r_mode == 4'd0) ? L_MAX_MODE : r_mode - 4'd1;
                end
            end
            CONFIRM: begin
                if (bus.game_over) begin
                    w_stateNext = MENU;
                end else if (bus.frame_tick && r_confCnt == L_CONF_LAST) begin
                    w_stateNext = PLAY;
                end
            end
            PLAY: begin
                if (bus.game_over) begin
                    w_stateNext = MENU;
                end
            end
            default: w_stateNext = MENU;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= MENU;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Mode register and the one-cycle start pulse on the CONFIRM->PLAY edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode      <= 4'd0;
            r_startGame <= 1'b0;
        end else begin
            r_mode      <= w_modeNext;
            r_startGame <= (r_state == CONFIRM) && (w_stateNext == PLAY);
        end
    end

    // Counts frame ticks while staying in CONFIRM, cleared on any exit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_confCnt <= '0;
        end else if (r_state != CONFIRM || w_stateNext != CONFIRM) begin
            r_confCnt <= '0;
        end else if (bus.frame_tick) begin
            r_confCnt <= r_confCnt + 1'b1;
        end
    end

`ifdef MODE_SEL_BLINK_EN
    localparam int L_BW = $clog2(BLINK_FRAMES) + 1;
    localparam logic [L_BW-1:0] L_BLINK_LAST = L_BW'(BLINK_FRAMES - 1);
    logic [L_BW-1:0] r_blinkCnt;
    logic            r_phase;

    // Blink timer runs only in MENU; any other state restarts it showing the digit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blinkCnt <= '0;
            r_phase    <= 1'b1;
        end else if (r_state != MENU) begin
            r_blinkCnt <= '0;
            r_phase    <= 1'b1;
        end else if (bus.frame_tick) begin
            if (r_blinkCnt == L_BLINK_LAST) begin
                r_blinkCnt <= '0;
                r_phase    <= ~r_phase;
            end else begin
                r_blinkCnt <= r_blinkCnt + 1'b1;
            end
        end
    end

    assign w_phase = r_phase;
`else
    assign w_phase = 1'b1;
`endif

    // Stage 0: box test and banner column; offsets compared in full 10 bits
    always_comb begin
        w_dx    = bus.pix_x - L_X0;
        w_dy    = bus.pix_y - L_Y0;
        w_inBox = bus.video_on && (bus.pix_x >= L_X0) && (w_dx < 10'd128) &&
                  (bus.pix_y >= L_Y0) && (w_dy < 10'd16);
        w_col   = w_dx[6:3];
        w_code  = bus.char_code_in;
        if (w_col == 4'd5) begin
            w_code = w_phase ? (7'h31 + {3'b000, r_mode}) : 7'h20;
        end
    end

    assign bus.char_xy = w_inBox ? {4'h0, w_col} : 8'h00;

    // Stages 1-3: font address, alignment with the font ROM, then pixel select
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fontAddr <= 11'd0;
            r_inBox1   <= 1'b0;
            r_bit1     <= 3'd0;
            r_inBox2   <= 1'b0;
            r_bit2     <= 3'd0;
            r_textOn   <= 1'b0;
        end else begin
            r_fontAddr <= {w_code, w_dy[3:0]};
            r_inBox1   <= w_inBox;
            r_bit1     <= w_dx[2:0];
            r_inBox2   <= r_inBox1;
            r_bit2     <= r_bit1;
            r_textOn   <= r_inBox2 && bus.font_row_in[w_bitSel] && (r_state != PLAY);
        end
    end

    assign w_bitSel       = 3'd7 - r_bit2;
    assign bus.font_addr  = r_fontAddr;
    assign bus.text_on    = r_textOn;
    assign bus.mode       = r_mode;
    assign bus.mode_valid = (r_state == PLAY);
    assign bus.start_game = r_startGame;

endmodule
